max7219_slave: RTL and testbench

MAX7219_SLAVE -- requirements
Module: max7219_slave

---
 rtl/max7219_pkg.sv | 52 +++++
 rtl/max7219_scan.sv | 75 +++++++
 rtl/max7219_slave.sv | 181 ++++++++++++++++++
 tb/tb_max7219_slave.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - shared MAX7219 address map, frame states and Code-B font
package max7219_pkg;

    localparam logic [3:0] NOOP      = 4'h0;
    localparam logic [3:0] DIGIT0    = 4'h1;
    localparam logic [3:0] DIGIT1    = 4'h2;
    localparam logic [3:0] DIGIT2    = 4'h3;
    localparam logic [3:0] DIGIT3    = 4'h4;
    localparam logic [3:0] DIGIT4    = 4'h5;
    localparam logic [3:0] DIGIT5    = 4'h6;
    localparam logic [3:0] DIGIT6    = 4'h7;
    localparam logic [3:0] DIGIT7    = 4'h8;
    localparam logic [3:0] DECODE    = 4'h9;
    localparam logic [3:0] INTENSITY = 4'hA;
    localparam logic [3:0] SCANLIM   = 4'hB;
    localparam logic [3:0] SHUTDOWN  = 4'hC;
    localparam logic [3:0] TEST      = 4'hF;

    localparam int WORD_BITS   = 16;
    localparam int NUM_DIGITS  = 8;
    localparam int NUM_SUBTICK = 16;

    typedef enum logic {
        FR_IDLE,
        FR_OPEN
    } frame_state_t;

    // Segment order {A,B,C,D,E,F,G}; DP is carried separately by the caller.
    function automatic logic [6:0] code_b(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'h0:    pat = 7'h7E;
            4'h1:    pat = 7'h30;
            4'h2:    pat = 7'h6D;
            4'h3:    pat = 7'h79;
            4'h4:    pat = 7'h33;
            4'h5:    pat = 7'h5B;
            4'h6:    pat = 7'h5F;
            4'h7:    pat = 7'h70;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h7B;
            4'hA:    pat = 7'h01;
            4'hB:    pat = 7'h4F;
            4'hC:    pat = 7'h37;
            4'hD:    pat = 7'h0E;
            4'hE:    pat = 7'h67;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/max7219_scan.sv
// rtl/max7219_scan.sv - digit multiplexer with 16-step PWM and Code-B decode
module max7219_scan
    import max7219_pkg::*;
#(
    parameter int SUB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0][7:0] digits,
    input  logic [7:0]      decode_mode,
    input  logic [3:0]      intensity,
    input  logic [2:0]      scan_limit,
    input  logic            shutdown_n,
    input  logic            display_test,
    output logic [7:0]      seg,
    output logic [7:0]      dig_n
);
    localparam int PW = (SUB_TICK > 1) ? $clog2(SUB_TICK) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SUB_TICK - 1);
    localparam logic [3:0] SUB_LAST = 4'(NUM_SUBTICK - 1);

    logic [PW-1:0] pre_q;
    logic [3:0]    sub_q;
    logic [2:0]    idx_q;
    logic [2:0]    limit;
    logic [7:0]    cur_digit;
    logic [7:0]    src;
    logic [7:0]    dig_sel;

    // Test mode overrides the limit; a lowered limit is honoured at the next slot boundary.
    assign limit = display_test ? 3'd7 : scan_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            sub_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            if (sub_q == SUB_LAST) begin
                sub_q <= '0;
                idx_q <= (idx_q >= limit) ? 3'd0 : idx_q + 3'd1;
            end else begin
                sub_q <= sub_q + 4'd1;
            end
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    assign cur_digit = digits[idx_q];
    assign dig_sel   = ~(8'd1 << idx_q);

    always_comb begin
        src = cur_digit;
        if (decode_mode[idx_q]) begin
            src = {cur_digit[7], code_b(cur_digit[3:0])};
        end
    end

    always_comb begin
        seg   = 8'h00;
        dig_n = 8'hFF;
        if (display_test) begin
            seg   = 8'hFF;
            dig_n = dig_sel;
        end else if (shutdown_n) begin
            dig_n = dig_sel;
            if (sub_q <= intensity) begin
                seg = src;
            end
        end
    end

endmodule

// File: rtl/max7219_slave.sv
// rtl/max7219_slave.sv - MAX7219-compatible serial slave: front end, register file, scanner
module max7219_slave
    import max7219_pkg::*;
#(
    parameter int SUB_TICK = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdin,
    input  logic        scs,
    input  logic        sclk,
    output logic        dout,
    output logic [7:0]  seg,
    output logic [7:0]  dig_n,
    output logic        word_valid,
    output logic [15:0] word_data,
    output logic        frame_err
);
    logic [1:0] scs_sync;
    logic [1:0] sclk_sync;
    logic [1:0] sdin_sync;
    logic       scs_prev;
    logic       sclk_prev;
    logic       scs_s;
    logic       sclk_s;
    logic       sdin_s;
    logic       scs_rise;
    logic       scs_fall;
    logic       sclk_rise;
    logic       sclk_fall;

    frame_state_t state_q;
    frame_state_t state_d;
    logic         shift_en;
    logic         latch_en;
    logic         err_en;
    logic         cnt_clr;
    logic [4:0]   bit_cnt;
    logic [15:0]  shreg;
    logic [3:0]   addr;
    logic [7:0]   data;

    logic [7:0][7:0] digits;
    logic [7:0]      decode_mode;
    logic [3:0]      intensity;
    logic [2:0]      scan_limit;
    logic            shutdown_n;
    logic            display_test;

    // Synchronizers reset low so a frame already open at reset release is never seen as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scs_sync  <= '0;
            sclk_sync <= '0;
            sdin_sync <= '0;
            scs_prev  <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            scs_sync  <= {scs_sync[0], scs};
            sclk_sync <= {sclk_sync[0], sclk};
            sdin_sync <= {sdin_sync[0], sdin};
            scs_prev  <= scs_sync[1];
            sclk_prev <= sclk_sync[1];
        end
    end

    assign scs_s     = scs_sync[1];
    assign sclk_s    = sclk_sync[1];
    assign sdin_s    = sdin_sync[1];
    assign scs_rise  = scs_s & ~scs_prev;
    assign scs_fall  = ~scs_s & scs_prev;
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The scs rise branch wins over a coincident sclk rise, dropping that bit.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        latch_en = 1'b0;
        err_en   = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            FR_IDLE: begin
                if (scs_fall) begin
                    state_d = FR_OPEN;
                    cnt_clr = 1'b1;
                end
            end
            FR_OPEN: begin
                if (scs_rise) begin
                    state_d = FR_IDLE;
                    if (bit_cnt >= 5'(WORD_BITS)) begin
                        latch_en = 1'b1;
                    end else begin
                        err_en = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: state_d = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            dout    <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (shift_en && bit_cnt != 5'(WORD_BITS)) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (shift_en) begin
                shreg <= {shreg[14:0], sdin_s};
            end
            if (sclk_fall) begin
                dout <= shreg[15];
            end
        end
    end

    assign addr = shreg[11:8];
    assign data = shreg[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_valid   <= 1'b0;
            frame_err    <= 1'b0;
            word_data    <= '0;
            digits       <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
        end else begin
            word_valid <= latch_en;
            frame_err  <= err_en;
            if (latch_en) begin
                word_data <= shreg;
                case (addr)
                    DIGIT0, DIGIT1, DIGIT2, DIGIT3,
                    DIGIT4, DIGIT5, DIGIT6, DIGIT7: digits[addr[2:0] - 3'd1] <= data;
                    DECODE:    decode_mode  <= data;
                    INTENSITY: intensity    <= data[3:0];
                    SCANLIM:   scan_limit   <= data[2:0];
                    SHUTDOWN:  shutdown_n   <= data[0];
                    TEST:      display_test <= data[0];
                    default: ;
                endcase
            end
        end
    end

    max7219_scan #(
        .SUB_TICK(SUB_TICK)
    ) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .decode_mode (decode_mode),
        .intensity   (intensity),
        .scan_limit  (scan_limit),
        .shutdown_n  (shutdown_n),
        .display_test(display_test),
        .seg         (seg),
        .dig_n       (dig_n)
    );

endmodule

// File: tb/tb_max7219_slave.sv
// tb/tb_max7219_slave.sv - self-checking bench for max7219_slave
module tb_max7219_slave;

    localparam int ST   = 2;
    localparam int SLOT = 16 * ST;
    localparam int H    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdin = 1'b0;
    logic        scs = 1'b1;
    logic        sclk = 1'b0;
    logic        dout;
    logic [7:0]  seg;
    logic [7:0]  dig_n;
    logic        word_valid;
    logic [15:0] word_data;
    logic        frame_err;

    int checks = 0;
    int failures = 0;

    max7219_slave #(.SUB_TICK(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sdin      (sdin),
        .scs       (scs),
        .sclk      (sclk),
        .dout      (dout),
        .seg       (seg),
        .dig_n     (dig_n),
        .word_valid(word_valid),
        .word_data (word_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    logic [6:0]  codeb_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                    7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};
    logic [7:0]  m_dig [8];
    logic [7:0]  m_decode;
    logic [3:0]  m_int;
    logic [2:0]  m_lim;
    logic        m_shut;
    logic        m_test;
    logic [15:0] m_word;
    logic [15:0] m_sh;
    int          m_cnt;
    bit          m_open;
    int          m_tick;
    int          m_idx;

    typedef struct {
        int          nbits;
        logic [31:0] bits;
        bit          collide;
        bit          exp_valid;
        logic [15:0] exp_word;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
        m_decode = 8'h00; m_int = 4'h0; m_lim = 3'd0; m_shut = 1'b0; m_test = 1'b0;
        m_word = 16'h0000; m_sh = 16'h0000; m_cnt = 0; m_open = 1'b0;
        m_tick = 0; m_idx = 0;
    endfunction

    function automatic void model_write(input logic [15:0] w);
        int a = int'(w[11:8]);
        m_word = w;
        if (a >= 1 && a <= 8) m_dig[a-1] = w[7:0];
        else if (a == 9)  m_decode = w[7:0];
        else if (a == 10) m_int = w[3:0];
        else if (a == 11) m_lim = w[2:0];
        else if (a == 12) m_shut = w[0];
        else if (a == 15) m_test = w[0];
    endfunction

    function automatic void exp_display(output logic [7:0] es, output logic [7:0] ed);
        logic [7:0] d = m_dig[m_idx];
        logic [7:0] src = m_decode[m_idx] ? {d[7], codeb_tab[d[3:0]]} : d;
        es = 8'h00;
        ed = 8'hFF;
        if (m_test) begin
            es = 8'hFF;
            ed[m_idx] = 1'b0;
        end else if (m_shut) begin
            ed[m_idx] = 1'b0;
            if (m_tick / ST <= int'(m_int)) es = src;
        end
    endfunction

    // Slot-level scanner reference: advance at +1, compare outputs at +3 after each edge.
    always begin
        logic [7:0] es, ed;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_tick = 0;
            m_idx = 0;
        end else if (m_tick == SLOT - 1) begin
            m_tick = 0;
            m_idx = (m_idx >= (m_test ? 7 : int'(m_lim))) ? 0 : m_idx + 1;
        end else begin
            m_tick++;
        end
        #2;
        exp_display(es, ed);
        chk("seg", 32'(seg), 32'(es));
        chk("dig_n", 32'(dig_n), 32'(ed));
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sclk_bit(input logic b);
        sclk = 1'b0;
        sdin = b;
        repeat (H) @(negedge clk);
        chk("dout", 32'(dout), 32'(m_sh[15]));
        sclk = 1'b1;
        if (m_open) begin
            m_sh = {m_sh[14:0], b};
            m_cnt++;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic open_frame();
        @(negedge clk);
        scs = 1'b0;
        m_open = 1'b1;
        m_cnt = 0;
        repeat (H) @(negedge clk);
    endtask

    task automatic end_frame(input bit collide, output bit seen);
        bit ev, ee;
        sclk = 1'b0;
        repeat (H) @(negedge clk);
        chk("dout_tail", 32'(dout), 32'(m_sh[15]));
        ev = m_open && m_cnt >= 16;
        ee = m_open && m_cnt < 16;
        if (collide) begin
            sdin = 1'b1;
            sclk = 1'b1;
        end
        scs = 1'b1;
        m_open = 1'b0;
        repeat (2) begin
            @(posedge clk); #3;
            chk("word_valid_early", 32'(word_valid), 32'd0);
            chk("frame_err_early", 32'(frame_err), 32'd0);
        end
        @(posedge clk); #2;
        if (ev) model_write(m_sh);
        #1;
        chk("word_valid", 32'(word_valid), 32'(ev));
        chk("frame_err", 32'(frame_err), 32'(ee));
        chk("word_data", 32'(word_data), 32'(m_word));
        seen = word_valid;
        @(posedge clk); #3;
        chk("word_valid_pulse", 32'(word_valid), 32'd0);
        chk("frame_err_pulse", 32'(frame_err), 32'd0);
        sclk = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_frame(input int n, input logic [31:0] bits, input bit collide, output bit seen);
        open_frame();
        for (int i = n - 1; i >= 0; i--) sclk_bit(bits[i]);
        end_frame(collide, seen);
    endtask

    task automatic wait_slot(input int idx, input int tick);
        bit found = 1'b0;
        for (int c = 0; c < 16 * SLOT && !found; c++) begin
            @(posedge clk); #3;
            if (m_idx == idx && m_tick == tick) found = 1'b1;
        end
        chk("slot_reached", 32'(found), 32'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [7:0] dseq [3] = '{8'hFD, 8'hFB, 8'hFE};
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_word_data", 32'(word_data), 32'h0000);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_dig_n", 32'(dig_n), 32'hFF);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        vecs[0]  = '{16, 32'h0000_0C01, 1'b0, 1'b1, 16'h0C01};
        vecs[1]  = '{16, 32'h0000_0B02, 1'b0, 1'b1, 16'h0B02};
        vecs[2]  = '{16, 32'h0000_0901, 1'b0, 1'b1, 16'h0901};
        vecs[3]  = '{16, 32'h0000_0105, 1'b0, 1'b1, 16'h0105};
        vecs[4]  = '{16, 32'h0000_0A00, 1'b0, 1'b1, 16'h0A00};
        vecs[5]  = '{10, 32'h0000_02AA, 1'b0, 1'b0, 16'h0A00};
        vecs[6]  = '{16, 32'h0000_0A0F, 1'b1, 1'b1, 16'h0A0F};
        vecs[7]  = '{24, 32'h00FF_0A03, 1'b0, 1'b1, 16'h0A03};
        vecs[8]  = '{15, 32'h0000_7FFF, 1'b0, 1'b0, 16'h0A03};
        vecs[9]  = '{16, 32'h0000_0D55, 1'b0, 1'b1, 16'h0D55};
        vecs[10] = '{16, 32'h0000_0000, 1'b0, 1'b1, 16'h0000};
        for (int v = 0; v < 11; v++) begin
            send_frame(vecs[v].nbits, vecs[v].bits, vecs[v].collide, seen);
            chk("vec_valid", 32'(seen), 32'(vecs[v].exp_valid));
            chk("vec_word", 32'(word_data), 32'(vecs[v].exp_word));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        do_reset(3);
        send_frame(16, 32'h0C01, 1'b0, seen);
        send_frame(16, 32'h0B02, 1'b0, seen);
        wait_slot(0, SLOT / 2);
        chk("scan_dig0", 32'(dig_n), 32'hFE);
        for (int s = 0; s < 3; s++) begin
            repeat (SLOT) @(posedge clk);
            #3;
            chk("scan_seq", 32'(dig_n), 32'(dseq[s]));
        end

        send_frame(16, 32'h0901, 1'b0, seen);
        send_frame(16, 32'h0105, 1'b0, seen);
        send_frame(16, 32'h0A00, 1'b0, seen);
        wait_slot(0, 0);
        chk("pwm_on", 32'(seg), 32'h5B);
        for (int t = 1; t < 16; t++) begin
            repeat (ST) @(posedge clk);
            #3;
            chk("pwm_off", 32'(seg), 32'h00);
        end

        send_frame(16, 32'h0208, 1'b0, seen);
        wait_slot(1, 0);
        chk("raw_digit1", 32'(seg), 32'h08);
        send_frame(16, 32'h0902, 1'b0, seen);
        wait_slot(1, 0);
        chk("codeb_digit1", 32'(seg), 32'h7F);

        send_frame(10, 32'h3FF, 1'b0, seen);
        chk("short_word_data", 32'(word_data), 32'h0902);
        send_frame(20, 32'hA0F01, 1'b0, seen);
        wait_slot(0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("test_seg", 32'(seg), 32'hFF);
            chk("test_dig", 32'(dig_n), 32'(8'hFF ^ (8'h01 << i)));
            repeat (SLOT) @(posedge clk);
            #3;
        end

        open_frame();
        for (int i = 0; i < 8; i++) sclk_bit(1'($urandom));
        do_reset(3);
        repeat (4) @(negedge clk);
        end_frame(1'b0, seen);
        chk("reset_frame_dropped", 32'(seen), 32'd0);
        send_frame(16, 32'h0C01, 1'b0, seen);
        chk("after_reset_word", 32'(word_data), 32'h0C01);

        for (int r = 0; r < 40; r++) begin
            logic [3:0] a;
            logic [7:0] d;
            int kind;
            a = 4'($urandom);
            d = 8'($urandom);
            if (a == 4'hF && $urandom_range(0, 3) != 0) a = 4'hC;
            kind = $urandom_range(0, 7);
            if (kind == 0) send_frame($urandom_range(1, 15), $urandom, 1'b0, seen);
            else if (kind == 1) send_frame($urandom_range(17, 24), {16'($urandom), 4'($urandom), a, d}, 1'b0, seen);
            else send_frame(16, {20'h0, a, d}, kind == 2, seen);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end

        repeat (2 * SLOT) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
